sample_src: RTL and testbench
=============================

SAMPLE_SRC -- requirements
Module: sample_src

Interface
REQ-001 Parameter HALF, default 4: syn_out high time and low time in clk cycles (legal 2..255).
REQ-002 Parameter DEPTH, default 4: input FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 res  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  1 = sample clock runs; 0 = sample clock held idle.
REQ-006 in_data  input  8  two's complement sample from the producer.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  FIFO can accept a word (not full).
REQ-009 data_out  output  8  sign-magnitude sample: bit7 = sign, bits6:0 = magnitude.
REQ-010 syn_out  output  1  sample clock; the receiver captures data_out on its rising edge.
REQ-011 frame_out  output  1  high for the whole high phase of every 16th sample.
REQ-012 underrun  output  1  one-cycle pulse when a sample slot finds the FIFO empty.

Function
REQ-013 A word is written when in_valid and in_ready are both 1 in the same cycle; in_ready = not full.
REQ-014 Phase counter ph runs 0..2*HALF-1 and wraps while en = 1; syn_out is registered, 1 for ph in 0..HALF-1 and 0 otherwise.
REQ-015 Load slot: the cycle in which ph = HALF-1. In that cycle the FIFO head is popped and converted, and data_out updates on the same edge on which syn_out falls. data_out therefore stays stable for HALF cycles before, and HALF cycles after, each rising edge.
REQ-016 Conversion: x >= 0 gives data_out = x. x < 0 gives {1, (-x)[6:0]}. x = -128 (0x80) saturates to 0xFF (-127).
REQ-017 If the FIFO is empty at a load slot: data_out = 0x00, underrun pulses for 1 cycle, and the sample counter still advances.
REQ-018 Sample counter sc (4 bits) increments at each load slot and wraps 15 -> 0. frame_out is registered, and is 1 during the syn_out high phase that follows the load of the sample with sc = 15.
REQ-019 When en goes 0: ph, syn_out and frame_out clear on the next edge, and data_out holds its value. The FIFO keeps accepting input. No pop occurs while en = 0.
REQ-020 When en goes 1: ph restarts at 0, and syn_out rises on the next edge.
REQ-021 Push and pop in the same cycle: both succeed. When full, the occupancy is unchanged and in_ready stays 0 for that cycle.
REQ-022 Latency: a word pushed into an empty FIFO appears on data_out at the next load slot that is at least 1 cycle after the push.
REQ-023 Write and read pointers wrap modulo DEPTH. The occupancy count is log2(DEPTH)+1 bits wide.

Reset
REQ-024 While res = 1, and on the first edge after res falls, the block holds the following values: FIFO empty, ph = 0, sc = 0, syn_out = 0, frame_out = 0, underrun = 0, data_out = 0x00, in_ready = 1.
REQ-025 Reset asserted mid-frame discards the FIFO contents and the partial frame. After release, the block starts a new frame at sc = 0.

Structure
REQ-026 A shared package holds: sample width 8, frame length 16, the saturation constant 0xFF, and the two's-complement-to-sign-magnitude conversion function.
REQ-027 The FIFO is one sub-module, sample_fifo (DEPTH x 8, push/pop/full/empty). The divider, conversion and frame logic are in the top level.

Verification
REQ-028 Push 0x05, 0xFB, 0x80, 0x7F; then en = 1, HALF = 4 -> data_out = 0x05, 0x85, 0xFF, 0x7F, each on successive syn_out falling edges. syn_out has period 8 and duty 50%.
REQ-029 en = 1 with the FIFO empty -> data_out = 0x00 and underrun pulses once per 8 cycles. No X appears on any output.
REQ-030 Push 16 words continuously -> frame_out is high exactly during the 16th syn_out high phase, and again 128 cycles later.
REQ-031 Hold in_valid = 1 with en = 0 -> in_ready drops after DEPTH = 4 pushes. Set en = 1 -> in_ready rises the cycle after the first pop.
REQ-032 Pulse res for 1 cycle mid-frame, with 3 words queued and sc = 9 -> all outputs return to reset values. The FIFO is empty and the next frame_out occurs after 16 new samples.
REQ-033 A receiver model that accumulates 16 samples on the syn_out rising edge, fed ramp values -8..7 -> the sum equals -8, matching a reference sum computed by the bench.

Source files
------------

// File: rtl/sample_src_pkg.sv
// Shared constants and the sample format conversion for the sample source.
package sample_src_pkg;

  localparam int unsigned SampleW  = 8;
  localparam int unsigned FrameLen = 16;
  localparam logic [SampleW-1:0] SatVal = 8'hFF;

  // Two's complement to sign-magnitude; the most negative code has no
  // magnitude representation, so it saturates to -127.
  function automatic logic [SampleW-1:0] to_sign_mag(input logic [SampleW-1:0] x);
    logic [SampleW-1:0] neg;
    neg = '0 - x;
    if (!x[SampleW-1]) begin
      to_sign_mag = x;
    end else if (x == {1'b1, {(SampleW-1){1'b0}}}) begin
      to_sign_mag = SatVal;
    end else begin
      to_sign_mag = {1'b1, neg[SampleW-2:0]};
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with a combinational head read.
module sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sample_src.sv
// Sample source: buffers producer samples, converts them to sign-magnitude and
// presents them against a divided sample clock with a 16-sample frame marker.
module sample_src
  import sample_src_pkg::*;
#(
  parameter int unsigned HALF  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  input  logic [SampleW-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SampleW-1:0] data_out,
  output logic               syn_out,
  output logic               frame_out,
  output logic               underrun
);

  localparam int unsigned PhW = $clog2(2 * HALF);
  localparam logic [PhW-1:0] PhLast = PhW'(2 * HALF - 1);
  localparam logic [PhW-1:0] PhLoad = PhW'(HALF - 1);
  localparam logic [PhW-1:0] PhHalf = PhW'(HALF);
  localparam int unsigned ScW = $clog2(FrameLen);
  localparam logic [ScW-1:0] ScLast = ScW'(FrameLen - 1);

  logic [SampleW-1:0] head;
  logic               full, empty;
  logic [PhW-1:0]     ph_q, ph_d;
  logic               run_q;
  logic [ScW-1:0]     sc_q;
  logic               arm_q;
  logic               syn_d;
  logic               load;

  assign in_ready = !full;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SampleW)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (load),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Next phase: the first enabled edge starts the high phase at ph = 0, so
  // syn_out always tracks ph in the same cycle.
  always_comb begin
    ph_d = '0;
    load = en && run_q && (ph_q == PhLoad);
    if (en && run_q) begin
      ph_d = (ph_q == PhLast) ? '0 : ph_q + PhW'(1);
    end
    syn_d = en && (ph_d < PhHalf);
  end

  // Divider, sample load/convert and frame marking.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ph_q      <= '0;
      run_q     <= 1'b0;
      sc_q      <= '0;
      arm_q     <= 1'b0;
      syn_out   <= 1'b0;
      frame_out <= 1'b0;
      underrun  <= 1'b0;
      data_out  <= '0;
    end else begin
      run_q     <= en;
      ph_q      <= ph_d;
      syn_out   <= syn_d;
      // arm_q marks that the sample now on data_out closes a frame.
      frame_out <= syn_d && arm_q;
      underrun  <= load && empty;
      if (load) begin
        sc_q     <= sc_q + ScW'(1);
        arm_q    <= (sc_q == ScLast);
        data_out <= empty ? '0 : to_sign_mag(head);
      end
    end
  end

endmodule

// File: tb/tb_sample_src.sv
// Scoreboard bench for sample_src: stimulus queues expected samples, a monitor
// compares them at each syn_out falling edge (the load edge).
module tb_sample_src;

  logic       clk = 1'b0;
  logic       res, en, in_valid;
  logic [7:0] in_data;
  logic       in_ready, syn_out, frame_out, underrun;
  logic [7:0] data_out;

  typedef struct packed {
    logic [7:0] d;
    logic       u;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         nfall = 0;
  int         rx_n = 0;
  int         rx_sum = 0;
  bit         rx_on = 1'b0;
  logic [7:0] ramp_tc [16];
  logic [7:0] ramp_sm [16] = '{8'h88, 8'h87, 8'h86, 8'h85, 8'h84, 8'h83, 8'h82, 8'h81,
                               8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

  always #5 clk = ~clk;

  sample_src #(
    .HALF  (4),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .res       (res),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .syn_out   (syn_out),
    .frame_out (frame_out),
    .underrun  (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_n(input logic [7:0] d, input logic u, input int n);
    repeat (n) exp_q.push_back({d, u});
  endtask

  task automatic wait_fall_cnt(input int target);
    int c;
    c = 0;
    while (nfall < target && c < 400) begin
      tick;
      c++;
    end
    chk("fall_wait", 32'(nfall >= target), 32'd1);
  endtask

  function automatic int sm2int(input logic [7:0] v);
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_syn"}, syn_out, 0);
    chk({tag, "_frame"}, frame_out, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  // Counts frame_out ticks over a run and records the first two frame starts.
  task automatic frame_run(input int len, output int first1, output int first2,
                           output int fcnt, output int fbad);
    first1 = 0;
    first2 = 0;
    fcnt   = 0;
    fbad   = 0;
    for (int t = 1; t <= len; t++) begin
      tick;
      if (frame_out === 1'b1) begin
        fcnt++;
        if (first1 == 0) first1 = t;
        else if (t > first1 + 8 && first2 == 0) first2 = t;
        if (syn_out !== 1'b1) fbad++;
      end
    end
  endtask

  // Monitor: samples on the falling clock edge, away from the active edge.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (res === 1'b1) begin
        prev = 1'b0;
      end else begin
        if (prev && syn_out === 1'b0) begin
          nfall++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sample: got data %0h underrun %0b want none",
                     data_out, underrun);
          end else begin
            e = exp_q.pop_front();
            chk("sample_data", data_out, e.d);
            chk("sample_underrun", underrun, e.u);
          end
        end
        // Receiver model: capture on the rising edge of syn_out.
        if (!prev && syn_out === 1'b1 && rx_on) begin
          if (rx_n >= 1 && rx_n <= 16) rx_sum += sm2int(data_out);
          rx_n++;
        end
        prev = syn_out;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         base, n, m, ucnt, xs, ref_sum, f1, f2, fc, fb;
    bit         feed_to;
    logic [7:0] pat;
    logic [7:0] a_in [4] = '{8'h05, 8'hFB, 8'h80, 8'h7F};

    for (int i = 0; i < 16; i++) ramp_tc[i] = 8'(i - 8);
    res = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick;
    check_reset_outs("reset");
    res = 1'b0;
    tick;
    chk("release_syn", syn_out, 0);
    chk("release_ready", in_ready, 1);

    // Conversion order, including saturation of 0x80.
    expect_n(8'h05, 1'b0, 1);
    expect_n(8'h85, 1'b0, 1);
    expect_n(8'hFF, 1'b0, 1);
    expect_n(8'h7F, 1'b0, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = a_in[i];
      tick;
    end
    in_valid = 1'b0;
    chk("full_ready", in_ready, 0);
    base = nfall;
    en = 1'b1;
    tick;
    chk("syn_first_rise", syn_out, 1);
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      tick;
      pat = {pat[6:0], syn_out};
    end
    chk("syn_shape", pat, 8'b1110_0001);
    wait_fall_cnt(base + 4);
    en = 1'b0;
    tick;
    chk("idle_syn", syn_out, 0);
    chk("idle_hold_data", data_out, 8'h7F);
    chk("queue_a", exp_q.size(), 0);

    // Empty FIFO: one underrun per sample period.
    expect_n(8'h00, 1'b1, 4);
    en = 1'b1;
    ucnt = 0;
    xs = 0;
    for (int i = 0; i < 32; i++) begin
      tick;
      if (underrun === 1'b1) ucnt++;
      if ($isunknown({in_ready, data_out, syn_out, frame_out, underrun})) xs++;
    end
    en = 1'b0;
    tick;
    chk("underrun_count", ucnt, 4);
    chk("no_x", xs, 0);
    chk("queue_b", exp_q.size(), 0);

    // Backpressure while idle, release after the first pop.
    expect_n(8'h11, 1'b0, 1);
    expect_n(8'h12, 1'b0, 1);
    expect_n(8'h13, 1'b0, 1);
    expect_n(8'h14, 1'b0, 1);
    n = 0;
    in_valid = 1'b1;
    in_data = 8'h11;
    while (in_ready === 1'b1 && n < 8) begin
      tick;
      n++;
      in_data = 8'(8'h11 + n);
    end
    chk("fill_count", n, 4);
    base = nfall;
    en = 1'b1;
    m = 0;
    while (in_ready !== 1'b1 && m < 20) begin
      tick;
      m++;
    end
    in_valid = 1'b0;
    chk("ready_after_pop", m, 5);
    wait_fall_cnt(base + 4);
    en = 1'b0;
    tick;
    chk("queue_c", exp_q.size(), 0);

    // Continuous ramp: frame marker and receiver sum.
    res = 1'b1;
    tick;
    res = 1'b0;
    tick;
    for (int i = 0; i < 16; i++) expect_n(ramp_sm[i], 1'b0, 1);
    expect_n(8'h00, 1'b1, 17);
    ref_sum = 0;
    for (int i = 0; i < 16; i++) ref_sum += int'($signed(ramp_tc[i]));
    rx_n = 0;
    rx_sum = 0;
    rx_on = 1'b1;
    feed_to = 1'b0;
    en = 1'b1;
    fork
      begin : feeder
        int   g;
        logic acc;
        for (int i = 0; i < 16; i++) begin
          in_data = ramp_tc[i];
          in_valid = 1'b1;
          g = 0;
          do begin
            acc = in_ready;
            tick;
            g++;
          end while (!acc && g < 100);
          if (g >= 100) feed_to = 1'b1;
        end
        in_valid = 1'b0;
      end
      frame_run(264, f1, f2, fc, fb);
    join
    en = 1'b0;
    tick;
    rx_on = 1'b0;
    chk("feed_timeout", feed_to, 0);
    chk("frame_first", f1, 129);
    chk("frame_second", f2, 257);
    chk("frame_ticks", fc, 8);
    chk("frame_outside_syn", fb, 0);
    chk("rx_sum", rx_sum, ref_sum);
    chk("queue_d", exp_q.size(), 0);

    // Reset mid-frame with sc = 9 and three words queued.
    res = 1'b1;
    tick;
    res = 1'b0;
    tick;
    expect_n(8'h00, 1'b1, 8);
    base = nfall;
    en = 1'b1;
    wait_fall_cnt(base + 8);
    en = 1'b0;
    tick;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h21 + i);
      tick;
    end
    in_valid = 1'b0;
    expect_n(8'h21, 1'b0, 1);
    base = nfall;
    en = 1'b1;
    wait_fall_cnt(base + 1);
    repeat (4) tick;
    chk("pre_reset_syn", syn_out, 1);
    chk("pre_reset_data", data_out, 8'h21);
    res = 1'b1;
    #1;
    check_reset_outs("async_reset");
    tick;
    res = 1'b0;
    expect_n(8'h00, 1'b1, 17);
    frame_run(136, f1, f2, fc, fb);
    en = 1'b0;
    tick;
    chk("post_reset_frame", f1, 129);
    chk("post_reset_frame_ticks", fc, 4);
    chk("queue_e", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
